// File: rtl/apb_master_bridge.sv
// APB requester: one valid/ready request at a time is run through the SETUP and ACCESS phases.
// Each result is returned on a valid/ready response port, and a wait-state timeout aborts hung transfers.
module apb_master_bridge #(
    parameter int unsigned DATAW   = 32,
    parameter int unsigned ADDRW   = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [ADDRW-1:0] req_addr,
    input  logic [DATAW-1:0] req_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_write,
    output logic [DATAW-1:0] rsp_rdata,
    output logic             rsp_timeout,
    output logic [ADDRW-1:0] paddr,
    output logic             psel,
    output logic             penable,
    output logic             pwrite,
    output logic [DATAW-1:0] pwdata,
    input  logic [DATAW-1:0] prdata,
    input  logic             pready
);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_e;

    localparam int unsigned   CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_e            state_q, state_d;
    logic [ADDRW-1:0]  paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATAW-1:0]  pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATAW-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic              rsp_timeout_q, rsp_timeout_d;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;
        wait_cnt_d    = wait_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    paddr_d    = req_addr;
                    pwrite_d   = req_write;
                    pwdata_d   = req_wdata;
                    wait_cnt_d = '0;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: state_d = S_ACCESS;
            S_ACCESS: begin
                // pready is tested first so a ready edge coinciding with the timeout edge completes normally
                if (pready) begin
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_write_d   = pwrite_q;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    state_d       = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                    if (TIMEOUT != 0 && wait_cnt_q == CNT_LAST) begin
                        rsp_rdata_d   = '0;
                        rsp_write_d   = pwrite_q;
                        rsp_timeout_d = 1'b1;
                        rsp_valid_d   = 1'b1;
                        state_d       = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        psel      = (state_q == S_SETUP) || (state_q == S_ACCESS);
        penable   = (state_q == S_ACCESS);
        req_ready = (state_q == S_IDLE) && rst_n;
    end

    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_write   = rsp_write_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge. A behavioural APB slave memory serves the requests.
// Transfers come from a vector table, random traffic and a mid-transfer reset sequence.
module tb_apb_master_bridge;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [7:0]  paddr;
    logic        psel, penable, pwrite, pready;
    logic [31:0] pwdata, prdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [logic [7:0]];

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          nwait;
        int          rdly;
        logic [31:0] exp_rdata;
        logic        exp_to;
    } vec_t;

    vec_t tbl [8];

    apb_master_bridge #(.DATAW(32), .ADDRW(8), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [7:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    task automatic xfer(input vec_t v);
        int k;
        int guard;
        int exp_cycles;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_addr  = 8'($urandom);
        req_wdata = $urandom;
        req_write = 1'($urandom);
        chk("setup_sel_en", {psel, penable}, 2'b10);
        chk("setup_paddr", paddr, v.addr);
        chk("setup_pwrite", pwrite, v.wr);
        chk("setup_pwdata", pwdata, v.wdata);
        chk("setup_req_ready", req_ready, 0);
        pready = 1'b0;
        prdata = $urandom;
        @(posedge clk); #1;
        chk("access_sel_en", {psel, penable}, 2'b11);
        k = 0;
        while (psel && penable && k < 200) begin
            k++;
            pready = (k > v.nwait);
            prdata = pready ? mem_rd(v.addr) : $urandom;
            @(posedge clk); #1;
            if (psel && k == 1) begin
                chk("access_paddr_hold", paddr, v.addr);
                chk("access_pwdata_hold", pwdata, v.wdata);
            end
        end
        pready = 1'b0;
        prdata = $urandom;
        exp_cycles = v.exp_to ? TO : v.nwait + 1;
        chk("access_cycles", k, exp_cycles);
        chk("done_sel_en", {psel, penable}, 2'b00);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, v.exp_rdata);
        chk("rsp_timeout", rsp_timeout, v.exp_to);
        if (!v.exp_to) chk("rsp_write", rsp_write, v.wr);
        chk("resp_req_ready", req_ready, 0);
        for (int i = 0; i < v.rdly; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("bp_req_ready", req_ready, 0);
            chk("bp_psel", psel, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("post_rsp_valid", rsp_valid, 0);
        chk("post_req_ready", req_ready, 1);
        chk("post_paddr_retained", paddr, v.addr);
        chk("post_pwrite_retained", pwrite, v.wr);
        if (v.wr && !v.exp_to) mem[v.addr] = v.wdata;
    endtask

    initial begin
        vec_t v;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = '0;

        tbl[0] = '{1'b1, 8'h12, 32'h0000_00A5, 0,   0, 32'h0,         1'b0};
        tbl[1] = '{1'b0, 8'h12, 32'h0,         0,   0, 32'h0000_00A5, 1'b0};
        tbl[2] = '{1'b1, 8'h40, 32'hDEAD_BEEF, 2,   1, 32'h0,         1'b0};
        tbl[3] = '{1'b0, 8'h40, 32'h0,         3,   0, 32'hDEAD_BEEF, 1'b0};
        tbl[4] = '{1'b0, 8'h12, 32'h0,         100, 0, 32'h0,         1'b1};
        tbl[5] = '{1'b1, 8'h33, 32'h1111_2222, 100, 2, 32'h0,         1'b1};
        tbl[6] = '{1'b0, 8'h12, 32'h0,         15,  0, 32'h0000_00A5, 1'b0};
        tbl[7] = '{1'b0, 8'h40, 32'h0,         0,   5, 32'hDEAD_BEEF, 1'b0};

        #2;
        chk("rst_sel_en", {psel, penable}, 2'b00);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_fields", {rsp_write, rsp_timeout, rsp_rdata}, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rel_req_ready", req_ready, 1);

        for (int i = 0; i < 8; i++) xfer(tbl[i]);
        chk("timed_out_write_absent", mem.exists(8'h33), 0);

        for (int i = 0; i < 40; i++) begin
            v.wr    = 1'($urandom_range(0, 1));
            v.addr  = 8'($urandom_range(0, 7));
            v.wdata = $urandom;
            v.nwait = ($urandom_range(0, 5) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 3));
            v.rdly  = int'($urandom_range(0, 3));
            v.exp_to = (v.nwait >= int'(TO));
            v.exp_rdata = (v.wr || v.exp_to) ? 32'h0 : mem_rd(v.addr);
            xfer(v);
        end

        // Reset asserted in the middle of an ACCESS wait state
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 8'h77;
        req_wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        req_valid = 1'b0;
        pready    = 1'b0;
        @(posedge clk); #1;
        chk("mid_access", {psel, penable}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("async_sel_en", {psel, penable}, 2'b00);
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_req_ready", req_ready, 0);
        chk("async_paddr", paddr, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("after_rst_req_ready", req_ready, 1);
        chk("after_rst_rsp_valid", rsp_valid, 0);
        mem.delete();
        v = '{1'b1, 8'h21, 32'h5A5A_0F0F, 1, 0, 32'h0, 1'b0};
        xfer(v);
        v = '{1'b0, 8'h21, 32'h0, 0, 1, 32'h5A5A_0F0F, 1'b0};
        xfer(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
